// File: rtl/fetch_top.sv
// Instruction-fetch stage: PC sequencing, single-outstanding icache requests,
// decode-side instruction FIFO and redirect flushing. Optional macro: FETCH_BYPASS_EN.
module fetch_top #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] BOOT_PC = 32'h0000_1000,
  parameter logic [PC_WIDTH-1:0] EXC_PC  = 32'h0000_2000,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                   clock,
  input  logic                   reset_c,
  output logic                   fetch_req_valid,
  output logic [PC_WIDTH-1:0]    fetch_req_pc,
  input  logic                   icache_req_ready,
  input  logic                   icache_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] icache_rsp_data,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   excV,
  input  logic                   stall_decode,
  output logic                   fetch_instr_valid,
  output logic [INSTR_WIDTH-1:0] fetch_instr_data,
  output logic [PC_WIDTH-1:0]    fetch_instr_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
  logic                   outstanding_q, outstanding_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [INSTR_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    fifo_pc_q   [FIFO_DEPTH];

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                credit;
  logic                req_accept;
  logic                rsp_take;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;

  assign redirect    = excV | branch_taken;
  assign redirect_pc = excV ? EXC_PC : branch_target;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign credit      = ({1'b0, count_q} + {{CNT_W{1'b0}}, outstanding_q}) < (CNT_W+1)'(FIFO_DEPTH);

  assign fetch_req_valid = (state_q == REQ) & credit;
  assign fetch_req_pc    = (state_q == REQ) ? pc_q : '0;
  assign req_accept      = fetch_req_valid & icache_req_ready;
  assign rsp_take        = (state_q == WAIT_RSP) & icache_rsp_valid;
  assign pop             = ~fifo_empty & ~stall_decode;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  // A response reaching an empty FIFO is shown to decode immediately; it is
  // only stored when decode stalls.
  assign bypass = fifo_empty & rsp_take & ~redirect;
  assign push   = rsp_take & ~redirect & ~(bypass & ~stall_decode);

  always_comb begin
    fetch_instr_valid = 1'b0;
    fetch_instr_data  = '0;
    fetch_instr_pc    = '0;
    if (!fifo_empty) begin
      fetch_instr_valid = 1'b1;
      fetch_instr_data  = fifo_data_q[rd_ptr_q];
      fetch_instr_pc    = fifo_pc_q[rd_ptr_q];
    end else if (bypass) begin
      fetch_instr_valid = 1'b1;
      fetch_instr_data  = icache_rsp_data;
      fetch_instr_pc    = req_pc_q;
    end
  end
`else
  assign push = rsp_take & ~redirect;

  always_comb begin
    fetch_instr_valid = 1'b0;
    fetch_instr_data  = '0;
    fetch_instr_pc    = '0;
    if (!fifo_empty) begin
      fetch_instr_valid = 1'b1;
      fetch_instr_data  = fifo_data_q[rd_ptr_q];
      fetch_instr_pc    = fifo_pc_q[rd_ptr_q];
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redirect_pc;
      end
      REQ: begin
        if (req_accept) begin
          pc_d          = pc_q + PC_WIDTH'(4);
          req_pc_d      = pc_q;
          outstanding_d = 1'b1;
          state_d       = WAIT_RSP;
        end
        // An accepted request that is redirected must still have its response drained.
        if (redirect) begin
          pc_d = redirect_pc;
          if (req_accept) state_d = DRAIN;
        end
      end
      WAIT_RSP: begin
        if (icache_rsp_valid) begin
          outstanding_d = 1'b0;
          state_d       = REQ;
        end
        if (redirect) begin
          pc_d = redirect_pc;
          if (!icache_rsp_valid) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (icache_rsp_valid) begin
          outstanding_d = 1'b0;
          state_d       = REQ;
        end
        if (redirect) pc_d = redirect_pc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      state_q       <= IDLE;
      pc_q          <= BOOT_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_q <= count_q + CNT_W'(1);
        else if (!push && pop) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= icache_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset_c) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_top.sv
// Self-checking bench for fetch_top: directed scenarios plus a randomized phase,
// checked against a transaction-level queue model of the fetch stage.
module tb_fetch_top;

  logic        clock = 1'b0;
  logic        reset_c = 1'b0;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_pc;
  logic        icache_req_ready = 1'b1;
  logic        icache_rsp_valid = 1'b0;
  logic [31:0] icache_rsp_data = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        excV = 1'b0;
  logic        stall_decode = 1'b0;
  logic        fetch_instr_valid;
  logic [31:0] fetch_instr_data;
  logic [31:0] fetch_instr_pc;

  fetch_top #(
    .PC_WIDTH   (32),
    .INSTR_WIDTH(32),
    .BOOT_PC    (32'h0000_1000),
    .EXC_PC     (32'h0000_2000),
    .FIFO_DEPTH (2)
  ) dut (
    .clock            (clock),
    .reset_c          (reset_c),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_pc     (fetch_req_pc),
    .icache_req_ready (icache_req_ready),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .excV             (excV),
    .stall_decode     (stall_decode),
    .fetch_instr_valid(fetch_instr_valid),
    .fetch_instr_data (fetch_instr_data),
    .fetch_instr_pc   (fetch_instr_pc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: instructions decode should see, and the single icache transaction in flight.
  ent_t        m_q[$];
  logic [31:0] m_pc       = 32'h1000;
  logic        m_idle     = 1'b0;
  logic        m_out      = 1'b0;
  logic        m_drop     = 1'b0;
  logic [31:0] m_out_pc   = '0;
  logic [31:0] m_out_data = '0;
  int unsigned rsp_wait   = 0;
  int unsigned rsp_lat    = 0;
  logic        rand_lat   = 1'b0;
  logic        stray      = 1'b0;
  logic        force_en   = 1'b0;
  logic        chk_byp    = 1'b0;
  int unsigned byp_seen   = 0;
  logic [31:0] dec_log[$];
  logic [31:0] req_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: entered and left at posedge+1 with the caller's inputs applied.
  task automatic cycle();
    logic exp_rv, exp_iv, redir, acc, rsp_t, byp, popd;
    if (m_out && rsp_wait == 0) begin
      icache_rsp_valid = 1'b1;
      icache_rsp_data  = m_out_data;
    end else begin
      icache_rsp_valid = stray;
      icache_rsp_data  = $urandom;
    end
    @(negedge clock);
    exp_rv = !m_idle && !m_out && (m_q.size() < 2);
    rsp_t  = m_out && icache_rsp_valid;
    redir  = excV || branch_taken;
    byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = rsp_t && !m_drop && !redir && (m_q.size() == 0);
`endif
    exp_iv = (m_q.size() != 0) || byp;
    check_b("req_valid", fetch_req_valid, exp_rv);
    if (exp_rv) check("req_pc", fetch_req_pc, m_pc);
    check_b("instr_valid", fetch_instr_valid, exp_iv);
    if (m_q.size() != 0) begin
      check("instr_pc", fetch_instr_pc, m_q[0].pc);
      check("instr_data", fetch_instr_data, m_q[0].data);
    end else if (byp) begin
      check("byp_pc", fetch_instr_pc, m_out_pc);
      check("byp_data", fetch_instr_data, m_out_data);
    end
    if (chk_byp && icache_rsp_valid) begin
`ifdef FETCH_BYPASS_EN
      check_b("bypass_valid", fetch_instr_valid, 1'b1);
      check("bypass_data", fetch_instr_data, 32'hDEAD_BEEF);
`else
      check_b("no_bypass_valid", fetch_instr_valid, 1'b0);
`endif
      byp_seen++;
      chk_byp = 1'b0;
    end
    acc  = exp_rv && icache_req_ready;
    popd = exp_iv && !stall_decode;
    if (popd) begin
      if (m_q.size() != 0) begin
        dec_log.push_back(m_q[0].pc);
        void'(m_q.pop_front());
      end else begin
        dec_log.push_back(m_out_pc);
      end
    end
    if (rsp_t) begin
      m_out = 1'b0;
      if (!m_drop && !redir && !(byp && !stall_decode))
        m_q.push_back('{pc: m_out_pc, data: m_out_data});
    end else if (m_out && rsp_wait != 0) begin
      rsp_wait--;
    end
    if (acc) begin
      req_log.push_back(m_pc);
      m_out      = 1'b1;
      m_drop     = 1'b0;
      m_out_pc   = m_pc;
      m_out_data = force_en ? 32'hDEAD_BEEF : $urandom;
      rsp_wait   = rand_lat ? $urandom_range(0, 3) : rsp_lat;
      m_pc       = m_pc + 32'd4;
    end
    if (redir) begin
      m_q.delete();
      if (m_out) m_drop = 1'b1;
      m_pc = excV ? 32'h2000 : branch_target;
    end
    m_idle = 1'b0;
    @(posedge clock);
    #1;
    stray = 1'b0;
  endtask

  task automatic do_reset();
    reset_c = 1'b1;
    icache_rsp_valid = 1'b0;
    #1;
    check_b("rst_req_valid", fetch_req_valid, 1'b0);
    check("rst_req_pc", fetch_req_pc, 32'h0);
    check_b("rst_instr_valid", fetch_instr_valid, 1'b0);
    check("rst_instr_data", fetch_instr_data, 32'h0);
    check("rst_instr_pc", fetch_instr_pc, 32'h0);
    m_q.delete();
    dec_log.delete();
    req_log.delete();
    m_pc   = 32'h1000;
    m_out  = 1'b0;
    m_drop = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_c = 1'b0;
    m_idle  = 1'b1;
  endtask

  initial begin
    int unsigned found, n, idx;

    #2;
    // Streaming with an immediately responding icache.
    do_reset();
    rsp_lat = 0;
    repeat (10) cycle();
    check("t1_req0", req_log[0], 32'h1000);
    if (dec_log.size() >= 3) begin
      check("t1_dec0", dec_log[0], 32'h1000);
      check("t1_dec1", dec_log[1], 32'h1004);
      check("t1_dec2", dec_log[2], 32'h1008);
    end else check("t1_dec_count", dec_log.size(), 3);

    // Decode stall fills the buffer and throttles requests.
    do_reset();
    stall_decode = 1'b1;
    repeat (10) cycle();
    check_b("t2_req_throttled", fetch_req_valid, 1'b0);
    check("t2_head_pc", fetch_instr_pc, 32'h1000);
    stall_decode = 1'b0;
    n = req_log.size();
    repeat (8) cycle();
    check("t2_dec0", dec_log[0], 32'h1000);
    check("t2_dec1", dec_log[1], 32'h1004);
    check("t2_resume_pc", req_log[n], 32'h1008);

    // Branch in the same cycle the 0x100C request is accepted.
    do_reset();
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (!m_idle && !m_out && m_q.size() < 2 && m_pc == 32'h100C) begin
        branch_taken  = 1'b1;
        branch_target = 32'h4000;
        found = 1;
      end
      cycle();
      branch_taken = 1'b0;
    end
    repeat (8) cycle();
    check("t3_found_100C", found, 1);
    n = 0;
    foreach (dec_log[i]) if (dec_log[i] == 32'h100C) n++;
    check("t3_100C_dropped", n, 0);
    idx = 0;
    foreach (req_log[i]) if (req_log[i] == 32'h100C) idx = i + 1;
    check("t3_next_req", (idx < req_log.size()) ? req_log[idx] : 32'hFFFF_FFFF, 32'h4000);

    // Exception and branch together while the buffer is full.
    do_reset();
    stall_decode = 1'b1;
    for (int i = 0; i < 20 && m_q.size() < 2; i++) cycle();
    check("t4_filled", m_q.size(), 2);
    excV = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h4000;
    cycle();
    excV = 1'b0;
    branch_taken = 1'b0;
    check_b("t4_flushed", fetch_instr_valid, 1'b0);
    n = req_log.size();
    stall_decode = 1'b0;
    repeat (6) cycle();
    check("t4_exc_pc", (n < req_log.size()) ? req_log[n] : 32'hFFFF_FFFF, 32'h2000);

    // Reset while a response is pending; stale response during IDLE.
    do_reset();
    rsp_lat = 3;
    for (int i = 0; i < 10 && !m_out; i++) cycle();
    check_b("t5_in_wait", m_out, 1'b1);
    do_reset();
    rsp_lat = 0;
    stray = 1'b1;
    repeat (8) cycle();
    check("t5_first_req", req_log[0], 32'h1000);
    check("t5_first_dec", dec_log[0], 32'h1000);

    // Response-to-decode latency with an empty buffer.
    do_reset();
    force_en = 1'b1;
    chk_byp  = 1'b1;
    byp_seen = 0;
    repeat (5) cycle();
    force_en = 1'b0;
    chk_byp  = 1'b0;
    check("t6_rsp_seen", byp_seen, 1);

    // Randomized traffic.
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall_decode     = ($urandom_range(0, 9) < 3);
      icache_req_ready = ($urandom_range(0, 9) < 7);
      branch_taken     = ($urandom_range(0, 19) == 0);
      branch_target    = 32'h3000 + ($urandom_range(0, 255) << 2);
      excV             = ($urandom_range(0, 49) == 0);
      stray            = !m_out && ($urandom_range(0, 9) == 0);
      cycle();
    end
    branch_taken = 1'b0;
    excV = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
